// File: rtl/spi_peripheral_pkg.sv
// Shared constants, state type and frame-validity helper for the SPI register-write target.
package uwasic_spi_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int FRAME_BITS = 16;
    // One past a full frame: any count that reaches this value marks an overlength frame.
    localparam logic [4:0] CNT_SAT = 5'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic frame_is_write(input logic [4:0] cnt,
                                            input logic [15:0] frame,
                                            input logic [6:0] max_addr);
        return (cnt == 5'(FRAME_BITS)) && frame[15] && (frame[14:8] <= max_addr);
    endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle: the controller drives all three lines, this block only listens.
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input sclk, input copi, input ncs);
endinterface

// File: rtl/spi_peripheral_sync_edge_det.sv
// Synchronizer chain plus history flop for one asynchronous pin, with rise/fall strobes.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   hist_q;

    // NOTE: non-blocking assignments here keep every flop sampling the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
            hist_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign level = chain_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode 0 write-only target: collects 16-bit frames and updates five PWM configuration registers.
module spi_peripheral
    import uwasic_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_peripheral_if.slave        spi,
    output logic [7:0]             en_reg_out_7_0,
    output logic [7:0]             en_reg_out_15_8,
    output logic [7:0]             en_reg_pwm_7_0,
    output logic [7:0]             en_reg_pwm_15_8,
    output logic [7:0]             pwm_duty_cycle
);

    logic sclk_rise, unused_sclk_level, unused_sclk_fall;
    logic ncs_level, ncs_rise, ncs_fall;
    logic copi_level, unused_copi_rise, unused_copi_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk),
        .level(unused_sclk_level), .rise(sclk_rise), .fall(unused_sclk_fall)
    );

    // Chip select resets high so releasing reset never fakes a frame start on an idle bus.
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .d(spi.copi),
        .level(copi_level), .rise(unused_copi_rise), .fall(unused_copi_fall)
    );

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_q;
    logic        commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && !ncs_level) begin
                        shift_q <= {shift_q[14:0], copi_level};
                        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    // A new frame may already be starting while this one commits.
                    if (ncs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign commit = (state == COMMIT) && frame_is_write(bit_cnt, shift_q, MAX_ADDR);

    // NOTE: these are discrete flops, not a memory array, so they take the reset like any other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (commit) begin
            case (shift_q[14:8])
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_q[7:0];
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_q[7:0];
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_q[7:0];
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_q[7:0];
                ADDR_DUTY:      pwm_duty_cycle  <= shift_q[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed and randomized frames against a register-file model updated 4 clk after nCS rises.
module tb_spi_peripheral;

    localparam int MODEL_MAX_ADDR = 4;
    localparam int COMMIT_DELAY   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_peripheral_if spi ();

    logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

    spi_peripheral dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi(spi),
        .en_reg_out_7_0(r_out_lo),
        .en_reg_out_15_8(r_out_hi),
        .en_reg_pwm_7_0(r_pwm_lo),
        .en_reg_pwm_15_8(r_pwm_hi),
        .pwm_duty_cycle(r_duty)
    );

    logic [7:0] exp_regs [5];
    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return r_out_lo;
            1: return r_out_hi;
            2: return r_pwm_lo;
            3: return r_pwm_hi;
            default: return r_duty;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 5; i++) check($sformatf("cycle_reg%0d", i), dut_reg(i), exp_regs[i]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    endtask

    // Sends nbits of 'bits' MSB first at SCLK = clk/8; rst_at >= 0 pulses reset after that many bits.
    task automatic send_frame(input logic [16:0] bits, input int nbits, input int rst_at, input int gap_clk);
        bit was_reset = 1'b0;
        spi.ncs = 1'b0;
        tick(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.copi = bits[i];
            tick(4);
            spi.sclk = 1'b1;
            tick(4);
            spi.sclk = 1'b0;
            if (nbits - i == rst_at) begin
                rst_n = 1'b0;
                tick(1);
                clear_model();
                tick(2);
                rst_n = 1'b1;
                was_reset = 1'b1;
            end
        end
        tick(4);
        spi.ncs = 1'b1;
        tick(COMMIT_DELAY);
        if (!was_reset && nbits == 16 && bits[15] && int'(bits[14:8]) <= MODEL_MAX_ADDR)
            exp_regs[int'(bits[14:8])] = bits[7:0];
        tick(gap_clk - COMMIT_DELAY);
    endtask

    task automatic toggle_sclk_idle(input int n);
        for (int i = 0; i < n; i++) begin
            spi.copi = 1'($urandom);
            spi.sclk = 1'b1;
            tick(4);
            spi.sclk = 1'b0;
            tick(4);
        end
    endtask

    initial begin
        clear_model();
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        rst_n    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_en = 1'b1;
        check("reset_out_lo", r_out_lo, 8'h00);
        check("reset_duty", r_duty, 8'h00);

        send_frame(17'h080F0, 16, -1, 8);
        check("w0_out_lo", r_out_lo, 8'hF0);
        check("w0_out_hi", r_out_hi, 8'h00);

        send_frame(17'h08480, 16, -1, 8);
        send_frame(17'h082FF, 16, -1, 8);
        send_frame(17'h0830F, 16, -1, 8);
        check("w_duty", r_duty, 8'h80);
        check("w_pwm_lo", r_pwm_lo, 8'hFF);
        check("w_pwm_hi", r_pwm_hi, 8'h0F);
        check("keep_out_lo", r_out_lo, 8'hF0);

        send_frame(17'h00055, 16, -1, 8);
        send_frame(17'h08A55, 16, -1, 8);
        send_frame(17'h07F22, 15, -1, 8);
        send_frame(17'h18022, 17, -1, 8);
        check("inval_out_lo", r_out_lo, 8'hF0);
        check("inval_out_hi", r_out_hi, 8'h00);
        check("inval_duty", r_duty, 8'h80);

        send_frame(17'h08011, 16, -1, 8);
        send_frame(17'h08122, 16, -1, 8);
        check("b2b_out_lo", r_out_lo, 8'h11);
        check("b2b_out_hi", r_out_hi, 8'h22);

        send_frame(17'h084AA, 16, 8, 8);
        check("midrst_duty", r_duty, 8'h00);
        check("midrst_out_lo", r_out_lo, 8'h00);
        check("midrst_pwm_lo", r_pwm_lo, 8'h00);
        send_frame(17'h084AA, 16, -1, 8);
        check("after_rst_duty", r_duty, 8'hAA);

        toggle_sclk_idle(12);
        check("idle_sclk_out_hi", r_out_hi, 8'h00);
        send_frame(17'h08133, 16, -1, 8);
        check("idle_sclk_w_out_hi", r_out_hi, 8'h33);
        check("idle_sclk_w_out_lo", r_out_lo, 8'h00);

        for (int n = 0; n < 40; n++) begin
            logic [6:0]  addr;
            logic [7:0]  data;
            logic        rw;
            logic [16:0] bits;
            int          nbits;
            int          sel;
            addr  = ($urandom % 8 == 0) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 7));
            data  = 8'($urandom);
            rw    = ($urandom % 4) != 0;
            sel   = int'($urandom % 6);
            nbits = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            bits  = {1'($urandom), rw, addr, data};
            if (nbits == 15) bits[16:15] = 2'b00;
            if (nbits == 16) bits[16] = 1'b0;
            if ($urandom % 5 == 0) toggle_sclk_idle(int'($urandom_range(1, 4)));
            send_frame(bits, nbits, -1, 8 + int'($urandom % 8));
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
